alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front-end that lets two requesters share one combinational ALU.
// A request is registered (EXEC), then its result is registered and held until consumed (RESP).

module alu #(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [m-1:0] sel,
  input  logic         cin,
  output logic [n-1:0] res,
  output logic         cout,
  output logic         flag_neg,
  output logic         flag_overflow,
  output logic         flag_null
);
  localparam int SW = $clog2(n);

  localparam logic [m-1:0] SEL_RCA      = m'(0);
  localparam logic [m-1:0] SEL_RCS      = m'(1);
  localparam logic [m-1:0] SEL_AND      = m'(2);
  localparam logic [m-1:0] SEL_OR       = m'(3);
  localparam logic [m-1:0] SEL_XOR      = m'(4);
  localparam logic [m-1:0] SEL_SHIFT_LS = m'(5);
  localparam logic [m-1:0] SEL_SHIFT_LD = m'(6);
  localparam logic [m-1:0] SEL_SHIFT_AS = m'(7);
  localparam logic [m-1:0] SEL_SHIFT_AD = m'(8);

  logic [n:0]    sum_s;
  logic [n:0]    sgn_s;
  logic [n:0]    ext_s;
  logic [SW-1:0] sh_s;

  // Zero-extended sums give the carry/borrow; sign-extended sums give overflow.
  // Shifts run one bit wider so the last bit shifted out lands in cout.
  always_comb begin
    sum_s         = '0;
    sgn_s         = '0;
    ext_s         = '0;
    res           = '0;
    cout          = 1'b0;
    flag_overflow = 1'b0;
    sh_s          = b[SW-1:0];
    case (sel)
      SEL_RCA: begin
        sum_s         = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
        sgn_s         = {a[n-1], a} + {b[n-1], b} + {{n{1'b0}}, cin};
        res           = sum_s[n-1:0];
        cout          = sum_s[n];
        flag_overflow = sgn_s[n] ^ sgn_s[n-1];
      end
      SEL_RCS: begin
        sum_s         = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, cin};
        sgn_s         = {a[n-1], a} - {b[n-1], b} - {{n{1'b0}}, cin};
        res           = sum_s[n-1:0];
        cout          = sum_s[n];
        flag_overflow = sgn_s[n] ^ sgn_s[n-1];
      end
      SEL_AND: res = a & b;
      SEL_OR:  res = a | b;
      SEL_XOR: res = a ^ b;
      SEL_SHIFT_LS: begin
        ext_s = {1'b0, a} << sh_s;
        res   = ext_s[n-1:0];
        cout  = ext_s[n];
      end
      SEL_SHIFT_LD: begin
        ext_s = {a, 1'b0} >> sh_s;
        res   = ext_s[n:1];
        cout  = ext_s[0];
      end
      SEL_SHIFT_AS: begin
        ext_s         = {1'b0, a} << sh_s;
        res           = ext_s[n-1:0];
        cout          = ext_s[n];
        flag_overflow = (($signed(ext_s[n-1:0]) >>> sh_s) != $signed(a));
      end
      SEL_SHIFT_AD: begin
        ext_s = $signed({a, 1'b0}) >>> sh_s;
        res   = ext_s[n:1];
        cout  = ext_s[0];
      end
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
    flag_neg  = res[n-1];
    flag_null = (res == '0);
  end
endmodule

module alu_arbiter #(
  parameter int n = 32,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic [m-1:0] req0_sel,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic [m-1:0] req1_sel,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_res,
  output logic         rsp_cout,
  output logic [2:0]   rsp_flags,
  output logic         busy
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic [n-1:0] op_a_q, op_a_d;
  logic [n-1:0] op_b_q, op_b_d;
  logic [m-1:0] op_sel_q, op_sel_d;
  logic         op_cin_q, op_cin_d;
  logic         op_id_q, op_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [n-1:0] rsp_res_q, rsp_res_d;
  logic         rsp_cout_q, rsp_cout_d;
  logic [2:0]   rsp_flags_q, rsp_flags_d;
  logic         busy_q, busy_d;

  logic         grant_any_s;
  logic         grant_id_s;
  logic         accept_s;
  logic [n-1:0] alu_res_s;
  logic         alu_cout_s;
  logic         alu_neg_s;
  logic         alu_ovf_s;
  logic         alu_null_s;

  // The ALU only ever sees the operand register, never a live requester payload.
  alu #(.n(n), .m(m)) u_alu (
    .a             (op_a_q),
    .b             (op_b_q),
    .sel           (op_sel_q),
    .cin           (op_cin_q),
    .res           (alu_res_s),
    .cout          (alu_cout_s),
    .flag_neg      (alu_neg_s),
    .flag_overflow (alu_ovf_s),
    .flag_null     (alu_null_s)
  );

  // Round-robin grant: prio only matters when both requesters are valid.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = prio_q;
    end else if (req0_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_any_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Next-state logic for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) state_d = ST_EXEC;
        else             state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
        else           state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs plus next values of the operand and response registers.
  always_comb begin
    accept_s    = (state_q == ST_IDLE) && grant_any_s;
    req0_ready  = accept_s && !grant_id_s;
    req1_ready  = accept_s && grant_id_s;
    prio_d      = prio_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    op_cin_d    = op_cin_q;
    op_id_d     = op_id_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_flags_d = rsp_flags_q;
    if (accept_s) begin
      prio_d  = !grant_id_s;
      op_id_d = grant_id_s;
      if (grant_id_s) begin
        op_a_d   = req1_a;
        op_b_d   = req1_b;
        op_sel_d = req1_sel;
        op_cin_d = req1_cin;
      end else begin
        op_a_d   = req0_a;
        op_b_d   = req0_b;
        op_sel_d = req0_sel;
        op_cin_d = req0_cin;
      end
    end else begin
      prio_d = prio_q;
    end
    if (state_q == ST_EXEC) begin
      rsp_id_d    = op_id_q;
      rsp_res_d   = alu_res_s;
      rsp_cout_d  = alu_cout_s;
      rsp_flags_d = {alu_neg_s, alu_ovf_s, alu_null_s};
    end else begin
      rsp_id_d = rsp_id_q;
    end
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, pointer and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operand and response registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_flags_q <= 3'b000;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      op_cin_q    <= op_cin_d;
      op_id_q     <= op_id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = busy_q;
endmodule
